// File: rtl/icache_assoc_core.sv
// N-way set-associative instruction-cache core: synchronous-read lookup pipeline,
// per-set round-robin victim choice, refill from the bus access unit and full-array sweep.
module icache_assoc_core #(
  parameter int PhysicalAddrWidth = 34,
  parameter int LineSize          = 16,
  parameter int IndexWidth        = 6,
  parameter int WayCount          = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         reqValid,
  output logic                                         reqReady,
  input  logic [PhysicalAddrWidth-$clog2(LineSize)-1:0] reqAddr,
  input  logic                                         flush,
  output logic                                         respValid,
  output logic [PhysicalAddrWidth-$clog2(LineSize)-1:0] respAddr,
  output logic [LineSize*8-1:0]                        respLine,
  output logic [PhysicalAddrWidth-$clog2(LineSize)-1:0] memAddr,
  output logic                                         memReadReq,
  input  logic                                         memReadGrant,
  input  logic [LineSize*8-1:0]                        memReadValue,
  input  logic                                         invalidateReq,
  output logic                                         invalidateDone
);

  localparam int OffW      = $clog2(LineSize);
  localparam int LineWidth = LineSize * 8;
  localparam int LineAddrW = PhysicalAddrWidth - OffW;
  localparam int TagW      = LineAddrW - IndexWidth;
  localparam int WayW      = (WayCount > 1) ? $clog2(WayCount) : 1;
  localparam int Sets      = 1 << IndexWidth;

  typedef enum logic [1:0] {Sweep, Lookup, Refill, Respond} cacheStateT;

  cacheStateT state, stateNxt;

  logic [WayCount-1:0]  validArr [Sets];
  logic [TagW-1:0]      tagArr   [WayCount][Sets];
  logic [LineWidth-1:0] dataArr  [WayCount][Sets];
  logic [WayW-1:0]      vicPtr   [Sets];

  logic [IndexWidth-1:0] sweepIdx;
  logic                  sweepLast, startSweep;
  logic                  invPending, sweepFromInv, respCancel;
  logic                  accept, missNow, fillWe;

  logic                 vld_p1;
  logic [LineAddrW-1:0] addr_p1;
  logic [WayCount-1:0]  valid_p1;
  logic [TagW-1:0]      tag_p1  [WayCount];
  logic [LineWidth-1:0] data_p1 [WayCount];
  logic [WayW-1:0]      ptr_p1;

  logic [WayCount-1:0]  hitVec;
  logic                 hit, allValid;
  logic [LineWidth-1:0] hitData;
  logic [WayW-1:0]      vicSel;

  logic [LineAddrW-1:0] missAddr;
  logic [WayW-1:0]      vicWay, vicPtrNxt;
  logic                 vicEvict;
  logic [LineWidth-1:0] fillLine;

  logic [IndexWidth-1:0] reqIdx, missIdx;
  logic [TagW-1:0]       missTag, lookupTag;

  assign reqIdx    = reqAddr[IndexWidth-1:0];
  assign missIdx   = missAddr[IndexWidth-1:0];
  assign missTag   = missAddr[LineAddrW-1:IndexWidth];
  assign lookupTag = addr_p1[LineAddrW-1:IndexWidth];
  assign sweepLast = &sweepIdx;
  assign fillWe    = (state == Refill) && memReadGrant;
  assign memAddr   = missAddr;
  assign missNow   = (state == Lookup) && vld_p1 && !hit && !flush;
  assign accept    = reqValid && reqReady && !flush;
  assign startSweep = (stateNxt == Sweep) && ((state != Sweep) || sweepLast);

  // Stage p1: tag compare across ways; the lowest matching way wins
  always_comb begin
    hitVec   = '0;
    hitData  = '0;
    vicSel   = ptr_p1;
    allValid = &valid_p1;
    for (int w = 0; w < WayCount; w++) begin
      hitVec[w] = valid_p1[w] && (tag_p1[w] == lookupTag);
    end
    for (int w = WayCount - 1; w >= 0; w--) begin
      if (hitVec[w]) hitData = data_p1[w];
      if (!valid_p1[w]) vicSel = WayW'(w);
    end
    hit = |hitVec;
  end

  always_comb begin
    stateNxt       = state;
    reqReady       = 1'b0;
    respValid      = 1'b0;
    respAddr       = addr_p1;
    respLine       = '0;
    memReadReq     = 1'b0;
    invalidateDone = 1'b0;
    case (state)
      Sweep: begin
        if (sweepLast) begin
          if (invPending || invalidateReq) begin
            stateNxt = Sweep;
          end else begin
            stateNxt       = Lookup;
            invalidateDone = sweepFromInv;
          end
        end
      end
      Lookup: begin
        reqReady = !invPending && !missNow;
        if (vld_p1 && hit && !flush) begin
          respValid = 1'b1;
          respLine  = hitData;
        end
        if (missNow) stateNxt = Refill;
        else if (invPending) stateNxt = Sweep;
      end
      Refill: begin
        memReadReq = 1'b1;
        if (memReadGrant) stateNxt = Respond;
      end
      Respond: begin
        respValid = !respCancel && !flush;
        respAddr  = missAddr;
        respLine  = fillLine;
        stateNxt  = invPending ? Sweep : Lookup;
      end
      default: stateNxt = Sweep;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= Sweep;
      sweepIdx     <= '0;
      vld_p1       <= 1'b0;
      invPending   <= 1'b0;
      sweepFromInv <= 1'b0;
      respCancel   <= 1'b0;
    end else begin
      state    <= stateNxt;
      vld_p1   <= accept;
      sweepIdx <= (state == Sweep) ? sweepIdx + 1'b1 : '0;
      if (startSweep) begin
        invPending   <= invalidateReq;
        sweepFromInv <= 1'b1;
      end else begin
        invPending <= invPending | invalidateReq;
      end
      if (missNow) respCancel <= 1'b0;
      else if ((state == Refill) && flush) respCancel <= 1'b1;
    end
  end

  // Stage p0 -> p1: synchronous array read; arrays and datapath carry no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1  <= reqAddr;
      valid_p1 <= validArr[reqIdx];
      ptr_p1   <= vicPtr[reqIdx];
      for (int w = 0; w < WayCount; w++) begin
        tag_p1[w]  <= tagArr[w][reqIdx];
        data_p1[w] <= dataArr[w][reqIdx];
      end
    end
    if (missNow) begin
      missAddr  <= addr_p1;
      vicWay    <= vicSel;
      vicEvict  <= allValid;
      vicPtrNxt <= (ptr_p1 == WayW'(WayCount - 1)) ? '0 : ptr_p1 + 1'b1;
    end
    if (state == Sweep) begin
      validArr[sweepIdx] <= '0;
      vicPtr[sweepIdx]   <= '0;
    end else if (fillWe) begin
      validArr[missIdx][vicWay] <= 1'b1;
      tagArr[vicWay][missIdx]   <= missTag;
      dataArr[vicWay][missIdx]  <= memReadValue;
      if (vicEvict) vicPtr[missIdx] <= vicPtrNxt;
    end
    if (fillWe) fillLine <= memReadValue;
  end

  assert property (@(posedge clk) disable iff (!rst) vld_p1 |-> $onehot0(hitVec));
  assert property (@(posedge clk) disable iff (!rst) memReadGrant |-> (state == Refill));

endmodule

// File: tb/tb_icache_assoc_core.sv
// Directed bench for icache_assoc_core: scoreboard of expected responses checked by a
// negedge monitor, plus inline checks of handshakes, refill timing, eviction, flush and invalidate.
module tb_icache_assoc_core;

  localparam int LAW = 30;
  localparam int LW  = 128;

  logic           clk = 1'b0;
  logic           rst;
  logic           reqValid, reqReady;
  logic [LAW-1:0] reqAddr;
  logic           flush;
  logic           respValid;
  logic [LAW-1:0] respAddr;
  logic [LW-1:0]  respLine;
  logic [LAW-1:0] memAddr;
  logic           memReadReq, memReadGrant;
  logic [LW-1:0]  memReadValue;
  logic           invalidateReq, invalidateDone;

  int nVec  = 0;
  int nFail = 0;

  logic [LAW-1:0] qAddr[$];
  logic [LW-1:0]  qLine[$];

  icache_assoc_core dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr), .flush(flush),
    .respValid(respValid), .respAddr(respAddr), .respLine(respLine),
    .memAddr(memAddr), .memReadReq(memReadReq), .memReadGrant(memReadGrant),
    .memReadValue(memReadValue), .invalidateReq(invalidateReq), .invalidateDone(invalidateDone)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] lineOf(input logic [LAW-1:0] a);
    return {a, 2'b00, ~a, 2'b01, a ^ 30'h2AAA_AAAA, 2'b10, a + 30'd7, 2'b11};
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Every response the DUT emits must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst === 1'b1 && respValid === 1'b1) begin
      if (qAddr.size() == 0) begin
        check("spuriousResp", respValid, 1'b0);
      end else begin
        check("respAddr", respAddr, qAddr.pop_front());
        check("respLine", respLine, qLine.pop_front());
      end
    end
  end

  task automatic lookup(input logic [LAW-1:0] a, input logic expHit,
                        input logic [LW-1:0] line, input logic push);
    int n;
    nextCycle();
    reqValid = 1'b1;
    reqAddr  = a;
    n = 0;
    #2;
    while (!reqReady && n < 300) begin
      nextCycle();
      #2;
      n++;
    end
    check("acceptReady", reqReady, 1'b1);
    if (push) begin
      qAddr.push_back(a);
      qLine.push_back(line);
    end
    nextCycle();
    reqValid = 1'b0;
    #2;
    check("lookupRespT1", respValid, expHit && push);
    check("lookupReadyT1", reqReady, expHit);
    check("noRefillReqT1", memReadReq, 1'b0);
    if (expHit) begin
      nextCycle();
      #2;
      check("hitNoRefill", memReadReq, 1'b0);
    end
  endtask

  task automatic serve(input logic [LAW-1:0] a, input logic [LW-1:0] line, input int delay,
                       input logic cancel, input logic inv);
    int n;
    nextCycle();
    #2;
    n = 0;
    while (!memReadReq && n < 50) begin
      nextCycle();
      #2;
      n++;
    end
    check("memReadReq", memReadReq, 1'b1);
    check("memAddr", memAddr, a);
    flush         = cancel;
    invalidateReq = inv;
    for (int d = 0; d < delay; d++) begin
      nextCycle();
      flush         = 1'b0;
      invalidateReq = 1'b0;
      #2;
      check("memReadReqHeld", memReadReq, 1'b1);
      check("memAddrStable", memAddr, a);
    end
    nextCycle();
    flush         = 1'b0;
    invalidateReq = 1'b0;
    memReadGrant  = 1'b1;
    memReadValue  = line;
    #2;
    check("noRespAtGrant", respValid, 1'b0);
    nextCycle();
    memReadGrant = 1'b0;
    memReadValue = '0;
    #2;
    check("respAtGrantPlus1", respValid, !cancel);
    check("reqDroppedAfterGrant", memReadReq, 1'b0);
  endtask

  task automatic missFill(input logic [LAW-1:0] a, input logic [LW-1:0] line, input int delay);
    lookup(a, 1'b0, line, 1'b1);
    serve(a, line, delay, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0]  lineA5;
    logic [LAW-1:0] b2b [3];
    logic [LAW-1:0] setA, setB, setC, setD;
    int cnt, pulses;
    logic doneSeen;

    lineA5 = {16{8'hA5}};
    b2b[0] = 30'h100; b2b[1] = 30'h140; b2b[2] = 30'h100;
    setA = {24'h10, 6'd3}; setB = {24'h11, 6'd3};
    setC = {24'h12, 6'd3}; setD = {24'h13, 6'd3};

    rst = 1'b0; reqValid = 1'b0; reqAddr = '0; flush = 1'b0;
    memReadGrant = 1'b0; memReadValue = '0; invalidateReq = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rstReqReady", reqReady, 1'b0);
    check("rstRespValid", respValid, 1'b0);
    check("rstMemReadReq", memReadReq, 1'b0);
    check("rstInvDone", invalidateDone, 1'b0);
    check("rstRespLine", respLine, '0);

    // Reset sweep: one set per cycle before lookups are accepted
    nextCycle();
    rst = 1'b1;
    cnt = 0;
    doneSeen = 1'b0;
    #2;
    while (!reqReady && cnt < 200) begin
      doneSeen |= invalidateDone;
      cnt++;
      nextCycle();
      #2;
    end
    check("resetSweepCycles", cnt, 64);
    check("resetNoInvDone", doneSeen, 1'b0);

    missFill(30'h100, lineA5, 2);
    lookup(30'h100, 1'b1, lineA5, 1'b1);
    missFill(30'h140, lineOf(30'h140), 0);

    // Back-to-back hits, one accept per cycle
    nextCycle();
    reqValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      reqAddr = b2b[i];
      #2;
      check("b2bReady", reqReady, 1'b1);
      if (i > 0) check("b2bRespValid", respValid, 1'b1);
      qAddr.push_back(b2b[i]);
      qLine.push_back(b2b[i] == 30'h100 ? lineA5 : lineOf(b2b[i]));
      nextCycle();
    end
    reqValid = 1'b0;
    #2;
    check("b2bRespValidLast", respValid, 1'b1);

    // Round-robin replacement in set 3
    missFill(setA, lineOf(setA), 1);
    missFill(setB, lineOf(setB), 0);
    missFill(setC, lineOf(setC), 0);
    lookup(setB, 1'b1, lineOf(setB), 1'b1);
    missFill(setD, lineOf(setD), 0);
    lookup(setC, 1'b1, lineOf(setC), 1'b1);
    missFill(setB, lineOf(setB), 0);

    // A request presented together with flush is not accepted
    nextCycle();
    reqValid = 1'b1;
    reqAddr  = 30'h7FF;
    flush    = 1'b1;
    nextCycle();
    reqValid = 1'b0;
    flush    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("flushReqNoRefill", memReadReq, 1'b0);
      check("flushReqNoResp", respValid, 1'b0);
      nextCycle();
    end

    // Flush during refill: no response, line still installed
    lookup(30'h200, 1'b0, lineOf(30'h200), 1'b0);
    serve(30'h200, lineOf(30'h200), 1, 1'b1, 1'b0);
    lookup(30'h200, 1'b1, lineOf(30'h200), 1'b1);

    // Invalidate during refill: refill and response complete, then a flagged sweep
    lookup(30'h300, 1'b0, lineOf(30'h300), 1'b1);
    serve(30'h300, lineOf(30'h300), 1, 1'b0, 1'b1);
    cnt = 0;
    pulses = 0;
    nextCycle();
    #2;
    while (!reqReady && cnt < 300) begin
      if (invalidateDone) pulses++;
      cnt++;
      nextCycle();
      #2;
    end
    check("invSweepCycles", cnt, 64);
    check("invDonePulses", pulses, 1);
    missFill(30'h200, lineOf(30'h200), 0);

    nextCycle();
    #2;
    check("scoreboardDrained", qAddr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
